// File: rtl/gf_pkg.sv
// gf_pkg: shared GF(2^8) definitions for the AES field (x^8 + x^4 + x^3 + x + 1).
// Used by both the log-side and exponent-side datapath modules.
//   gf_t           - one field element
//   GF_POLY        - reduction polynomial low byte (x^8 implied)
//   GF_GEN         - primitive generator used for the log/exp tables
//   GF_ORDER       - order of the multiplicative group
//   gf_xtime       - multiply by x (i.e. by 0x02) with reduction
//   gf_log_state_t - log table builder / server states
package gf_pkg;

    typedef logic [7:0] gf_t;

    localparam gf_t         GF_POLY  = 8'h1B;
    localparam gf_t         GF_GEN   = 8'h03;
    localparam int unsigned GF_ORDER = 255;

    typedef enum logic [0:0] {
        StInit,
        StRun
    } gf_log_state_t;

    function automatic gf_t gf_xtime(input gf_t x, input gf_t poly);
        return {x[6:0], 1'b0} ^ (x[7] ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/gf_mul_gen.sv
// gf_mul_gen: combinational multiply of a field element by the constant GEN.
// Parameters:
//   POLY - reduction polynomial low byte
//   GEN  - constant multiplier
// Ports:
//   x - field element in
//   y - x * GEN in GF(2^8)
module gf_mul_gen
    import gf_pkg::*;
#(
    parameter gf_t POLY = GF_POLY,
    parameter gf_t GEN  = GF_GEN
) (
    input  gf_t x,
    output gf_t y
);

    // Shift-and-add over the constant's bits; folds to xtime(x)^x for GEN=3.
    always_comb begin
        gf_t acc;
        gf_t pw;
        acc = 8'h00;
        pw  = x;
        for (int i = 0; i < 8; i++) begin
            if (GEN[i]) begin
                acc = acc ^ pw;
            end
            pw = gf_xtime(pw, POLY);
        end
        y = acc;
    end

endmodule

// File: rtl/gf_log_lookup.sv
// gf_log_lookup: sequential GF(2^8) logarithm unit, log base GEN.
// After reset it fills a 256-entry log table by walking GEN^k for k = 0..254
// (255 cycles), then answers one lookup per cycle over a valid/ready stream
// with a single registered output stage.
// Optional feature macro: GF_LOG_INV_EN adds out_inv_log (log of x^-1).
// Parameters:
//   POLY - reduction polynomial low byte (x^8 implied)
//   GEN  - generator; the table is only correct for a primitive element
// Ports:
//   clk         - rising-edge clock
//   rst_n       - synchronous active-low reset
//   in_valid    - input element valid
//   in_ready    - unit can accept in_data this cycle
//   in_data     - field element x
//   out_valid   - result valid
//   out_ready   - downstream accepts result
//   out_log     - log_GEN(x), 0..254; 0 when x == 0
//   out_zero    - x was 0 (log undefined)
//   init_done   - table build complete
//   out_inv_log - (GF_LOG_INV_EN only) log of x^-1
module gf_log_lookup
    import gf_pkg::*;
#(
    parameter gf_t POLY = GF_POLY,
    parameter gf_t GEN  = GF_GEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  gf_t  in_data,
    output logic out_valid,
    input  logic out_ready,
    output gf_t  out_log,
    output logic out_zero,
    output logic init_done
`ifdef GF_LOG_INV_EN
    ,
    output gf_t  out_inv_log
`endif
);

    gf_log_state_t state_q;
    gf_t           x_q;
    gf_t           x_next;
    gf_t           k_q;
    logic          init_done_q;
    logic          out_valid_q;
    gf_t           out_log_q;
    logic          out_zero_q;

    // Entry 0 is never written: a primitive generator never yields 0.
    gf_t log_mem [256];

    logic mem_we;
    logic xfer;
    logic is_zero;
    gf_t  log_val;

    gf_mul_gen #(
        .POLY (POLY),
        .GEN  (GEN)
    ) u_mul_gen (
        .x (x_q),
        .y (x_next)
    );

    assign in_ready = init_done_q && (!out_valid_q || out_ready);
    assign xfer     = in_valid && in_ready;
    assign is_zero  = (in_data == 8'h00);
    assign log_val  = is_zero ? 8'h00 : log_mem[in_data];
    assign mem_we   = rst_n && (state_q == StInit);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            log_mem[x_q] <= k_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StInit;
            x_q         <= 8'h01;
            k_q         <= 8'h00;
            init_done_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_log_q   <= 8'h00;
            out_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                StInit: begin
                    // The k == 254 write is the last one; the group has 255 elements.
                    if (k_q == 8'd254) begin
                        state_q     <= StRun;
                        init_done_q <= 1'b1;
                    end else begin
                        x_q <= x_next;
                        k_q <= k_q + 8'd1;
                    end
                end
                StRun: begin
                    state_q <= StRun;
                end
                default: state_q <= StInit;
            endcase

            // A push in the same cycle as a pop simply overwrites the stage.
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_log_q   <= log_val;
                out_zero_q  <= is_zero;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_log   = out_log_q;
    assign out_zero  = out_zero_q;
    assign init_done = init_done_q;

`ifdef GF_LOG_INV_EN
    gf_t out_inv_log_q;
    gf_t inv_val;

    // log(x^-1) = -log(x) mod 255; log 0 maps to 0, which also covers x == 0.
    assign inv_val = (log_val == 8'h00) ? 8'h00 : gf_t'(GF_ORDER) - log_val;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_inv_log_q <= 8'h00;
        end else if (xfer) begin
            out_inv_log_q <= inv_val;
        end
    end

    assign out_inv_log = out_inv_log_q;
`endif

endmodule

// File: tb/tb_gf_log_lookup.sv
module tb_gf_log_lookup;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_log;
    logic       out_zero;
    logic       init_done;
`ifdef GF_LOG_INV_EN
    logic [7:0] out_inv_log;
`endif

    gf_log_lookup dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_log   (out_log),
        .out_zero  (out_zero),
        .init_done (init_done)
`ifdef GF_LOG_INV_EN
        ,
        .out_inv_log (out_inv_log)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference tables from plain field arithmetic.
    logic [7:0] exp_tab [256];
    logic [7:0] log_tab [256];

    // Transaction-level expectation of the output stage.
    bit         init_ok;
    bit         m_valid;
    logic [7:0] m_log;
    bit         m_zero;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: drive at negedge, check in_ready, update model at the edge,
    // check the registered outputs at the following negedge.
    task automatic cycle(input bit v, input logic [7:0] d, input bit r);
        bit rdy;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        rdy = init_ok && (!m_valid || r);
        chk("in_ready", {7'd0, in_ready}, {7'd0, rdy});
        @(posedge clk);
        if (v && rdy) begin
            m_valid = 1'b1;
            m_zero  = (d == 8'h00);
            m_log   = (d == 8'h00) ? 8'h00 : log_tab[d];
        end else if (r) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        chk("out_valid", {7'd0, out_valid}, {7'd0, m_valid});
        if (m_valid) begin
            chk("out_log", out_log, m_log);
            chk("out_zero", {7'd0, out_zero}, {7'd0, m_zero});
`ifdef GF_LOG_INV_EN
            chk("out_inv_log", out_inv_log, (m_log == 8'h00) ? 8'h00 : 8'd255 - m_log);
`endif
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'($urandom);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_init_done", {7'd0, init_done}, 8'h00);
        chk("rst_out_valid", {7'd0, out_valid}, 8'h00);
        chk("rst_out_log", out_log, 8'h00);
        chk("rst_out_zero", {7'd0, out_zero}, 8'h00);
        chk("rst_in_ready", {7'd0, in_ready}, 8'h00);
`ifdef GF_LOG_INV_EN
        chk("rst_out_inv_log", out_inv_log, 8'h00);
`endif
        rst_n   = 1'b1;
        init_ok = 1'b0;
        m_valid = 1'b0;
    endtask

    // 255 build edges with in_valid held high: nothing accepted, then init_done.
    task automatic check_init_seq();
        for (int i = 0; i < 255; i++) begin
            in_valid  = 1'b1;
            in_data   = 8'($urandom);
            out_ready = 1'($urandom);
            #1;
            chk("init_done_low", {7'd0, init_done}, 8'h00);
            chk("init_in_ready", {7'd0, in_ready}, 8'h00);
            chk("init_out_valid", {7'd0, out_valid}, 8'h00);
            @(posedge clk);
            @(negedge clk);
        end
        chk("init_done_high", {7'd0, init_done}, 8'h01);
        init_ok = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] dir_in  [5];
        logic [7:0] dir_log [5];
        dir_in  = '{8'h01, 8'h03, 8'h02, 8'hFF, 8'hF6};
        dir_log = '{8'h00, 8'h01, 8'h19, 8'h07, 8'hFE};

        exp_tab[0] = 8'h01;
        for (int i = 1; i < 256; i++) exp_tab[i] = gmul(exp_tab[i-1], 8'h03);
        log_tab[0] = 8'h00;
        for (int i = 0; i < 255; i++) log_tab[exp_tab[i]] = 8'(i);

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        init_ok = 1'b0; m_valid = 1'b0; m_log = 8'h00; m_zero = 1'b0;
        @(negedge clk);

        do_reset();
        check_init_seq();

        // Directed back-to-back lookups.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, dir_in[i], 1'b1);
            chk("dir_log", out_log, dir_log[i]);
        end
        cycle(1'b0, 8'h00, 1'b1);

        // Zero input.
        cycle(1'b1, 8'h00, 1'b1);
        chk("zero_flag", {7'd0, out_zero}, 8'h01);
        chk("zero_log", out_log, 8'h00);
`ifdef GF_LOG_INV_EN
        chk("zero_inv", out_inv_log, 8'h00);
        cycle(1'b1, 8'h02, 1'b1);
        chk("inv_02", out_inv_log, 8'hE6);
        cycle(1'b1, 8'h01, 1'b1);
        chk("inv_01", out_inv_log, 8'h00);
`endif
        cycle(1'b0, 8'h00, 1'b1);

        // Backpressure: hold, then release with B and C back to back.
        cycle(1'b1, 8'h10, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'h20, 1'b0);
            chk("held_log", out_log, log_tab[8'h10]);
        end
        cycle(1'b1, 8'h20, 1'b1);
        chk("bp_b", out_log, log_tab[8'h20]);
        cycle(1'b1, 8'h30, 1'b1);
        chk("bp_c", out_log, log_tab[8'h30]);
        cycle(1'b0, 8'h00, 1'b1);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Reset in RUN with a pending result, then again at cycle 100 of INIT.
        cycle(1'b1, 8'h55, 1'b0);
        do_reset();
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        do_reset();
        check_init_seq();

        // Exhaustive sweep: exp(log(x)) must return x.
        for (int x = 1; x < 256; x++) begin
            cycle(1'b1, 8'(x), 1'b1);
            chk("sweep_exp", exp_tab[out_log], 8'(x));
        end
        cycle(1'b0, 8'h00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gf_log_lookup.md
# gf_log_lookup

- Sequential GF(2^8) logarithm unit (AES field, polynomial 0x11B, generator 0x03).
- Inverse of the exponent-table lookup in the AES datapath: maps a field element x to L where 3^L = x.
- After reset it self-builds its log table by iterating the generator. It then serves one lookup per cycle over a valid/ready stream.
- Feeds log-domain arithmetic: multiply = add logs mod 255, then exponent lookup.

## Interface
Parameters:
- POLY, 8'h1B, reduction polynomial low byte (x^8 implied)
- GEN, 8'h03, generator; table is correct only for a primitive element

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset; one clock, reset is synchronous and active-low
- in_valid  in  1  input element valid
- in_ready  out  1  unit can accept in_data this cycle
- in_data  in  8  field element x
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_log  out  8  log_GEN(x), range 0..254; 0 when x==0
- out_zero  out  1  x was 0 (log undefined)
- init_done  out  1  table build complete
- out_inv_log  out  8  only with GF_LOG_INV_EN; log of x^-1

## Operation
- Storage: 256x8 register array `log_mem`, no reset. Entry 0 is never written and never read.
- FSM states:
  - INIT: builder regs `x`=1, `k`=0 on reset. Each cycle: write `log_mem[x]`=k; x ← x·GEN (xtime(x)^x for GEN=3); k ← k+1. After the write with k==254, go to RUN.
  - RUN: serve lookups. Stays in RUN until reset.
- Input acceptance:
  - in_ready = init_done && (!out_valid || out_ready).
  - Transfer occurs when in_valid && in_ready.
- On transfer, the output register loads:
  - out_log = (in_data==0) ? 0 : log_mem[in_data]
  - out_zero = (in_data==0)
  - out_valid ← 1
- Output holds stable while out_valid && !out_ready.
- out_valid clears when out_ready is high and no new transfer occurs.
- Simultaneous pop and push: new result replaces old in the same cycle; throughput is one per cycle.
- in_data is ignored when in_ready is 0, including during INIT.
- Reset mid-INIT restarts the build from x=1, k=0. Reset in RUN drops any pending result; table contents are rebuilt.

## Timing
- Reset values: init_done=0, out_valid=0, out_log=0, out_zero=0, out_inv_log=0, in_ready=0.
- Table build: 255 write cycles.
  - First rising edge with rst_n high performs write k=0.
  - init_done=1 after the 255th such edge; in_ready may rise in that same cycle.
- Lookup latency: 1 cycle. Data accepted at edge N gives out_valid=1 after edge N.
- Arithmetic:
  - k is 8-bit and never exceeds 254.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? POLY : 0).

## Configuration
- Macro GF_LOG_INV_EN.
- Defined: adds port out_inv_log, registered alongside out_log.
  - out_inv_log = (L==0) ? 0 : 255-L, computed 8-bit.
  - Forced 0 when out_zero.
  - No added latency.
- Undefined: port and logic absent; all other behaviour identical.

## Structure
- Package gf_pkg holds:
  - typedef gf_t (logic [7:0])
  - constants GF_POLY=8'h1B, GF_GEN=8'h03, GF_ORDER=255
  - function gf_xtime
- Exponent-side modules share the same package.
- One sub-module: gf_mul_gen, a combinational x·GEN step used by the INIT builder.
- FSM, table and stream register stay in gf_log_lookup.

## Test plan
- Reset, then hold in_valid=1 → in_ready=0 and init_done=0 for exactly 255 cycles; init_done=1 on the next.
- After init, sequential inputs 0x01, 0x03, 0x02, 0xFF, 0xF6 → out_log 0x00, 0x01, 0x19, 0x07, 0xFE, one per cycle with out_ready=1.
- in_data=0x00 → out_zero=1, out_log=0x00. Under GF_LOG_INV_EN, out_inv_log=0x00.
- With GF_LOG_INV_EN: 0x02 → out_inv_log=0xE6; 0x01 → 0x00.
- out_ready=0 for 3 cycles with in_valid=1 → result held stable, in_ready=0, no input lost. Release → back-to-back results in order.
- Assert rst_n=0 at cycle 100 of INIT, then release → full 255-cycle rebuild. Exhaustive sweep of all 255 nonzero x: exp(out_log)==x for every x.
